// File: rtl/data_memory_responder_pkg.sv
// data_memory_pkg
// Shared types and constants for the data memory responder slice.
//   state_t    : responder FSM states (IDLE, WAIT, RESPOND)
//   WORD_W     : data word width in bits
//   BYTE_LANES : byte lanes per word (one byte-enable bit each)
package data_memory_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_responder_ram.sv
// data_memory_ram
// Single-port synchronous word RAM with per-byte write enables.
// A read returns the word as it was before any write on the same edge.
// Ports:
//   clk     : clock, rising edge
//   en      : access enable (read and/or write this edge)
//   we      : write enable, qualified by en
//   byte_en : lane i writes wdata[8i+7:8i]
//   addr    : word index
//   wdata   : write data
//   rdata   : registered read data, valid the cycle after an enabled access
module data_memory_ram
  import data_memory_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] byte_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately never cleared; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
          if (byte_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder
// Memory-side responder for CPU load/store requests. A request is accepted
// in IDLE, waits WAIT_CYCLES cycles, then performs the RAM access on the edge
// that enters RESPOND. The response is presented one cycle later and held
// until rsp_ready. Optional macro DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
// adds rsp_fault and turns misaligned accesses into faulting no-ops.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_write         : 1 = store, 0 = load
//   req_addr          : byte address (wraps modulo DEPTH*4)
//   req_wdata/byte_en : store data and lane enables
//   rsp_valid/ready   : response handshake
//   rsp_rdata         : load data, 0 for store acknowledges
//   rsp_is_write      : response belongs to a store
//   rsp_fault         : misaligned access (macro builds only)
//   stall             : a request is outstanding
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int  DEPTH       = 1024,
  parameter int  WAIT_CYCLES = 2,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [BYTE_LANES-1:0] req_byte_en,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_W-1:0]     rsp_rdata,
  output logic                  rsp_is_write,
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
  output logic                  rsp_fault,
`endif
  output logic                  stall
);

`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
  localparam bit CHECK_MISALIGN = 1'b1;
`else
  localparam bit CHECK_MISALIGN = 1'b0;
`endif

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_write;
  logic                  lat_mis;
  logic [ADDR_W-1:0]     lat_idx;
  logic [WORD_W-1:0]     lat_wdata;
  logic [BYTE_LANES-1:0] lat_be;

  logic                  accept;
  logic                  req_mis;
  logic                  ram_en;
  logic                  ram_we;
  logic [BYTE_LANES-1:0] ram_be;
  logic [ADDR_W-1:0]     ram_addr;
  logic [WORD_W-1:0]     ram_wdata;
  logic [WORD_W-1:0]     ram_rdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // Handshake flags follow the state register directly; holding off ready
  // during reset keeps a request from slipping in on the reset edge.
  assign req_ready = (state == IDLE) && !rst;
  assign stall     = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign req_mis   = CHECK_MISALIGN && (req_addr[1:0] != 2'b00);

  // The RAM is touched exactly once per request, on the edge entering
  // RESPOND. With zero wait states that edge is the accept edge itself, so
  // the live request fields feed the RAM; otherwise the latched copies do.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = lat_be;
    ram_addr  = lat_idx;
    ram_wdata = lat_wdata;
    if (accept && (WAIT_CYCLES == 0)) begin
      ram_en    = 1'b1;
      ram_we    = req_write && !req_mis;
      ram_be    = req_byte_en;
      ram_addr  = req_addr[ADDR_W+1:2];
      ram_wdata = req_wdata;
    end else if ((state == WAIT) && (cnt == 4'd1) && !rst) begin
      ram_en = 1'b1;
      ram_we = lat_write && !lat_mis;
    end
  end

  data_memory_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en      (ram_en),
    .we      (ram_we),
    .byte_en (ram_be),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  // Request FSM. The first RESPOND cycle waits for the synchronous RAM read;
  // the response registers load on the next edge and then hold until the
  // consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_write    <= 1'b0;
      lat_mis      <= 1'b0;
      lat_idx      <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_is_write <= 1'b0;
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
      rsp_fault    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_mis   <= req_mis;
            lat_idx   <= req_addr[ADDR_W+1:2];
            lat_wdata <= req_wdata;
            lat_be    <= req_byte_en;
            cnt       <= WAIT_INIT;
            state     <= (WAIT_CYCLES > 0) ? WAIT : RESPOND;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESPOND;
        end
        RESPOND: begin
          if (!rsp_valid) begin
            rsp_valid    <= 1'b1;
            rsp_rdata    <= (lat_write || lat_mis) ? '0 : ram_rdata;
            rsp_is_write <= lat_write;
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
            rsp_fault    <= lat_mis;
`endif
          end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_is_write <= 1'b0;
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
            rsp_fault    <= 1'b0;
`endif
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
// Drives two responders (WAIT_CYCLES = 2 and WAIT_CYCLES = 0) from one
// initial block and compares every response against a word-array model.
// Macro DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN enables the rsp_fault model.
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int WC0   = 2;
  localparam int WC1   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid    [2];
  logic        req_write    [2];
  logic        rsp_ready    [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [3:0]  req_byte_en  [2];
  logic        req_ready    [2];
  logic        rsp_valid    [2];
  logic        rsp_is_write [2];
  logic        stall        [2];
  logic [31:0] rsp_rdata    [2];
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
  logic        rsp_fault    [2];
`endif

  logic [31:0] model [2][DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid[0]),
    .req_ready    (req_ready[0]),
    .req_write    (req_write[0]),
    .req_addr     (req_addr[0]),
    .req_wdata    (req_wdata[0]),
    .req_byte_en  (req_byte_en[0]),
    .rsp_valid    (rsp_valid[0]),
    .rsp_ready    (rsp_ready[0]),
    .rsp_rdata    (rsp_rdata[0]),
    .rsp_is_write (rsp_is_write[0]),
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
    .rsp_fault    (rsp_fault[0]),
`endif
    .stall        (stall[0])
  );

  data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid[1]),
    .req_ready    (req_ready[1]),
    .req_write    (req_write[1]),
    .req_addr     (req_addr[1]),
    .req_wdata    (req_wdata[1]),
    .req_byte_en  (req_byte_en[1]),
    .rsp_valid    (rsp_valid[1]),
    .rsp_ready    (rsp_ready[1]),
    .rsp_rdata    (rsp_rdata[1]),
    .rsp_is_write (rsp_is_write[1]),
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
    .rsp_fault    (rsp_fault[1]),
`endif
    .stall        (stall[1])
  );

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a plain word array per instance, byte lanes merged
  // on stores, word index = byte address / 4 modulo DEPTH.
  task automatic modelStep(input int s, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] exp_rd, output logic exp_fault);
    int   idx;
    logic mis;
    idx = int'((addr >> 2) % DEPTH);
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
    mis = (addr % 4) != 0;
`else
    mis = 1'b0;
`endif
    exp_fault = mis;
    exp_rd    = 32'h0;
    if (wr) begin
      if (!mis) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model[s][idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end else if (!mis) begin
      exp_rd = model[s][idx];
    end
  endtask

  // Called at the falling edge just after the accept edge; waits (bounded)
  // for the response, checks it, then checks the IDLE bubble after handshake.
  task automatic collect(input int s, input logic wr, input logic [31:0] exp_rd, input logic exp_fault);
    int cyc = 0;
    while (rsp_valid[s] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput($sformatf("latency[%0d]", s), 32'(cyc), 32'((s == 0) ? WC0 + 1 : WC1 + 1));
    checkOutput($sformatf("rsp_is_write[%0d]", s), 32'(rsp_is_write[s]), 32'(wr));
    checkOutput($sformatf("rsp_rdata[%0d]", s), rsp_rdata[s], exp_rd);
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_FAULT_EN
    checkOutput($sformatf("rsp_fault[%0d]", s), 32'(rsp_fault[s]), 32'(exp_fault));
`else
    if (exp_fault) $display("[TB] unexpected fault expectation");
`endif
    @(negedge clk);
    checkOutput($sformatf("rsp_drop[%0d]", s), 32'(rsp_valid[s]), 32'd0);
    checkOutput($sformatf("bubble_ready[%0d]", s), 32'(req_ready[s]), 32'd1);
  endtask

  // One complete request/response with the consumer always ready.
  task automatic applyStimulus(input int s, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] exp_rd;
    logic        exp_fault;
    modelStep(s, wr, addr, wdata, be, exp_rd, exp_fault);
    @(negedge clk);
    checkOutput($sformatf("ready_before[%0d]", s), 32'(req_ready[s]), 32'd1);
    req_valid[s]   = 1'b1;
    req_write[s]   = wr;
    req_addr[s]    = addr;
    req_wdata[s]   = wdata;
    req_byte_en[s] = be;
    rsp_ready[s]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    checkOutput($sformatf("stall_busy[%0d]", s), 32'(stall[s]), 32'd1);
    collect(s, wr, exp_rd, exp_fault);
  endtask

  initial begin
    logic [31:0] exp1, exp2;
    logic        f1, f2;
    logic [31:0] a;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]   = 1'b0;
      req_write[s]   = 1'b0;
      req_addr[s]    = 32'h0;
      req_wdata[s]   = 32'h0;
      req_byte_en[s] = 4'h0;
      rsp_ready[s]   = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("reset_rsp_valid[%0d]", s), 32'(rsp_valid[s]), 32'd0);
      checkOutput($sformatf("reset_stall[%0d]", s), 32'(stall[s]), 32'd0);
      checkOutput($sformatf("reset_req_ready[%0d]", s), 32'(req_ready[s]), 32'd1);
      checkOutput($sformatf("reset_rsp_rdata[%0d]", s), rsp_rdata[s], 32'd0);
      checkOutput($sformatf("reset_rsp_is_write[%0d]", s), 32'(rsp_is_write[s]), 32'd0);
    end

    $display("[TB] initialising words 0..15");
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        applyStimulus(s, 1'b1, 32'(w * 4), $urandom, 4'hF);

    $display("[TB] store then load");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0);
    checkOutput("model_deadbeef", model[0][4], 32'hDEADBEEF);

    $display("[TB] byte lanes");
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0);
    checkOutput("model_merge", model[0][8], 32'h11BB33DD);
    applyStimulus(0, 1'b1, 32'h20, 32'h55555555, 4'b0000);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0);

    $display("[TB] backpressure");
    modelStep(0, 1'b0, 32'h10, 32'h0, 4'h0, exp1, f1);
    modelStep(0, 1'b0, 32'h20, 32'h0, 4'h0, exp2, f2);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_addr[0] = 32'h20;
    for (int i = 0; i < 40 && rsp_valid[0] !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      checkOutput("bp_rsp_rdata", rsp_rdata[0], exp1);
      checkOutput("bp_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    checkOutput("bp_drop", 32'(rsp_valid[0]), 32'd0);
    checkOutput("bp_bubble_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("bp_bubble_stall", 32'(stall[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    checkOutput("bp_pending_accepted", 32'(stall[0]), 32'd1);
    collect(0, 1'b0, exp2, f2);

    $display("[TB] address wrap, zero wait states");
    applyStimulus(1, 1'b1, 32'h1000, 32'h00000001, 4'hF);
    applyStimulus(1, 1'b0, 32'h0000, 32'h0, 4'h0);
    checkOutput("model_wrap", model[1][0], 32'h00000001);

    $display("[TB] reset during WAIT");
    applyStimulus(0, 1'b1, 32'h40, 32'h0, 4'hF);
    @(negedge clk);
    req_valid[0]   = 1'b1;
    req_write[0]   = 1'b1;
    req_addr[0]    = 32'h40;
    req_wdata[0]   = 32'hFFFFFFFF;
    req_byte_en[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    checkOutput("abort_in_wait", 32'(stall[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
    end
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0);
    checkOutput("model_abort", model[0][16], 32'h00000000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 60; n++) begin
      for (int s = 0; s < 2; s++) begin
        a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
        applyStimulus(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
